// File: rtl/ifu_fetch_queue.sv
// Multi-lane in-order fetch queue between IFU and decode: compacts up to ENQ_W lanes in, shows up to DEQ_W head slots out.
// Latency: 1 cycle enqueue-to-output when registered; 0 cycles via bypass when the queue is empty and BYPASS_EN=1.
// Backpressure: enq_ready_o drops when a full group no longer fits (registered state only); the IFU must hold the group.
module ifu_fetch_queue #(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned ENQ_W     = 4,
   parameter int unsigned DEQ_W     = 4,
   parameter int unsigned ILEN      = 32,
   parameter int unsigned VLEN      = 32,
   parameter bit          BYPASS_EN = 1'b1
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           flush_i,
   input  logic                           enq_valid_i,
   input  logic [ENQ_W-1:0]               enq_mask_i,
   input  logic [ENQ_W*ILEN-1:0]          enq_instr_i,
   input  logic [ENQ_W*VLEN-1:0]          enq_pc_i,
   input  logic [ENQ_W-1:0]               enq_pred_i,
   output logic                           enq_ready_o,
   output logic [DEQ_W-1:0]               deq_valid_o,
   output logic [DEQ_W*ILEN-1:0]          deq_instr_o,
   output logic [DEQ_W*VLEN-1:0]          deq_pc_o,
   output logic [DEQ_W-1:0]               deq_pred_o,
   input  logic [$clog2(DEQ_W+1)-1:0]     deq_num_i,
   output logic [$clog2(DEPTH+1)-1:0]     count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int EW = $clog2(ENQ_W+1);
   localparam int NW = $clog2(DEQ_W+1);

   typedef struct packed {
      logic            pred;
      logic [VLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [PW-1:0]   head_q;
   logic [PW-1:0]   tail_q;
   logic [CW-1:0]   count_q;

   entry_t          comp_ent [ENQ_W];
   logic [EW-1:0]   n_enq;
   logic [EW-1:0]   n_enq_eff;
   logic            enq_fire;
   logic            bypass_act;
   logic [NW-1:0]   n_avail;
   logic [NW-1:0]   n_deq;

   assign enq_ready_o = (count_q <= CW'(DEPTH - ENQ_W));
   assign enq_fire    = enq_valid_i & enq_ready_o;
   assign n_enq_eff   = enq_fire ? n_enq : '0;
   assign bypass_act  = BYPASS_EN && (count_q == '0) && enq_fire;
   assign count_o     = count_q;

   // Count valid lanes in the incoming fetch group.
   always_comb begin
      n_enq = '0;
      for (int l = 0; l < ENQ_W; l++) begin
         n_enq = n_enq + EW'(enq_mask_i[l]);
      end
   end

   // Compact set lanes in ascending order: output k takes the lane with exactly k set lanes below it.
   always_comb begin : blk_compact
      logic [EW-1:0] below;
      below = '0;
      for (int k = 0; k < ENQ_W; k++) begin
         comp_ent[k] = '0;
         below       = '0;
         for (int l = 0; l < ENQ_W; l++) begin
            if (enq_mask_i[l] && (below == EW'(k))) begin
               comp_ent[k] = '{pred:  enq_pred_i[l],
                               pc:    enq_pc_i[l*VLEN +: VLEN],
                               instr: enq_instr_i[l*ILEN +: ILEN]};
            end
            below = below + EW'(enq_mask_i[l]);
         end
      end
   end

   // Head slot view: stored entries normally, compacted lanes when bypassing an empty queue.
   for (genvar i = 0; i < DEQ_W; i++) begin : g_slot
      entry_t ram_ent;
      entry_t slot_ent;
      logic   ram_vld;
      logic   byp_vld;
      assign ram_ent = mem_q[head_q + PW'(i)];
      assign ram_vld = int'(count_q) > i;
      if (BYPASS_EN && (i < ENQ_W)) begin : g_byp
         assign byp_vld  = int'(n_enq) > i;
         assign slot_ent = bypass_act ? comp_ent[i] : ram_ent;
      end else begin : g_nobyp
         assign byp_vld  = 1'b0;
         assign slot_ent = ram_ent;
      end
      assign deq_valid_o[i]             = bypass_act ? byp_vld : ram_vld;
      assign deq_instr_o[i*ILEN +: ILEN] = slot_ent.instr;
      assign deq_pc_o[i*VLEN +: VLEN]    = slot_ent.pc;
      assign deq_pred_o[i]              = slot_ent.pred;
   end

   // Clamp the consumer's request to the number of slots actually presented.
   always_comb begin
      n_avail = '0;
      for (int i = 0; i < DEQ_W; i++) begin
         n_avail = n_avail + NW'(deq_valid_o[i]);
      end
      n_deq = (deq_num_i < n_avail) ? deq_num_i : n_avail;
   end

   // Pointer and occupancy update; reset beats flush, flush beats enqueue/dequeue.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_q + PW'(n_deq);
         tail_q  <= tail_q + PW'(n_enq_eff);
         count_q <= count_q + CW'(n_enq_eff) - CW'(n_deq);
      end
   end

   // Storage write; lanes already consumed through the bypass are skipped, their slots are popped at once.
   always_ff @(posedge clk_i) begin
      if (rst_ni && !flush_i && enq_fire) begin
         for (int k = 0; k < ENQ_W; k++) begin
            if ((int'(n_enq) > k) && !(bypass_act && (int'(n_deq) > k))) begin
               mem_q[tail_q + PW'(k)] <= comp_ent[k];
            end
         end
      end
   end

   // Catch consumers that take more slots than are presented; the datapath clamps regardless.
   always_ff @(posedge clk_i) begin
      if (rst_ni) begin
         assert (int'(deq_num_i) <= int'(n_avail));
      end
   end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: one registered-output and one bypass instance, checked against a queue scoreboard.
// Latency: model expects registered slots one cycle after enqueue, same cycle when bypassing an empty queue.
// Backpressure: model accepts a group only when a full group fits; dropped groups never reach the scoreboard.
module tb_ifu_fetch_queue;

   localparam int DEPTH = 16;
   localparam int ENQ_W = 4;
   localparam int DEQ_W = 4;

   typedef struct packed {
      logic        pred;
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         flush     [2];
   logic         enq_valid [2];
   logic [3:0]   enq_mask  [2];
   logic [127:0] enq_instr [2];
   logic [127:0] enq_pc    [2];
   logic [3:0]   enq_pred  [2];
   logic [2:0]   deq_num   [2];
   logic         enq_ready [2];
   logic [3:0]   deq_valid [2];
   logic [127:0] deq_instr [2];
   logic [127:0] deq_pc    [2];
   logic [3:0]   deq_pred  [2];
   logic [4:0]   count     [2];

   // Instance 0 has a strictly registered output, instance 1 has the empty-queue bypass.
   for (genvar g = 0; g < 2; g++) begin : g_dut
      ifu_fetch_queue #(
         .DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W), .ILEN(32), .VLEN(32), .BYPASS_EN(g == 1)
      ) u_dut (
         .clk_i       (clk),
         .rst_ni      (rst_n),
         .flush_i     (flush[g]),
         .enq_valid_i (enq_valid[g]),
         .enq_mask_i  (enq_mask[g]),
         .enq_instr_i (enq_instr[g]),
         .enq_pc_i    (enq_pc[g]),
         .enq_pred_i  (enq_pred[g]),
         .enq_ready_o (enq_ready[g]),
         .deq_valid_o (deq_valid[g]),
         .deq_instr_o (deq_instr[g]),
         .deq_pc_o    (deq_pc[g]),
         .deq_pred_o  (deq_pred[g]),
         .deq_num_i   (deq_num[g]),
         .count_o     (count[g])
      );
   end

   int   checks   = 0;
   int   failures = 0;
   ent_t sb0 [$];
   ent_t sb1 [$];

   task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs(input int d);
      flush[d]     = 1'b0;
      enq_valid[d] = 1'b0;
      enq_mask[d]  = 4'b0;
      enq_instr[d] = '0;
      enq_pc[d]    = '0;
      enq_pred[d]  = 4'b0;
      deq_num[d]   = 3'd0;
   endtask

   // One cycle on instance d: drive, compare outputs with the scoreboard, then advance the scoreboard.
   task automatic step(input int d, input bit v, input logic [3:0] m, input int dn_req,
                       input bit fl, input logic [31:0] base);
      ent_t         q [$];
      ent_t         lanes [$];
      ent_t         e;
      logic [127:0] pcs, ins, obs;
      logic [3:0]   prd, ev;
      int           sz, avail, dn;
      bit           fire, byp;
      if (d == 0) q = sb0; else q = sb1;
      @(negedge clk);
      idle_inputs(1 - d);
      sz   = q.size();
      fire = v && ((DEPTH - sz) >= ENQ_W);
      for (int l = 0; l < ENQ_W; l++) begin
         e.pc    = base + 32'(4 * l);
         e.instr = $urandom;
         e.pred  = 1'($urandom_range(0, 1));
         pcs[l*32 +: 32] = e.pc;
         ins[l*32 +: 32] = e.instr;
         prd[l]          = e.pred;
         if (m[l]) lanes.push_back(e);
      end
      byp = (d == 1) && fire && (sz == 0);
      if (byp) foreach (lanes[k]) q.push_back(lanes[k]);
      avail = (q.size() < DEQ_W) ? q.size() : DEQ_W;
      dn    = (dn_req < avail) ? dn_req : avail;
      flush[d]     = fl;
      enq_valid[d] = v;
      enq_mask[d]  = m;
      enq_instr[d] = ins;
      enq_pc[d]    = pcs;
      enq_pred[d]  = prd;
      deq_num[d]   = 3'(dn);
      #1;
      check_eq($sformatf("count%0d", d), count[d], sz);
      check_eq($sformatf("enq_ready%0d", d), enq_ready[d], (DEPTH - sz) >= ENQ_W);
      ev = 4'b0;
      for (int i = 0; i < DEQ_W; i++) if (i < q.size()) ev[i] = 1'b1;
      check_eq($sformatf("deq_valid%0d", d), deq_valid[d], ev);
      for (int i = 0; i < avail; i++) begin
         obs = {deq_pred[d][i], deq_pc[d][i*32 +: 32], deq_instr[d][i*32 +: 32]};
         check_eq($sformatf("slot%0d_%0d", d, i), obs, q[i]);
      end
      if (fl) begin
         q.delete();
      end else begin
         repeat (dn) void'(q.pop_front());
         if (fire && !byp) foreach (lanes[k]) q.push_back(lanes[k]);
      end
      if (d == 0) sb0 = q; else sb1 = q;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle_inputs(0);
      idle_inputs(1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      sb0.delete();
      sb1.delete();
   endtask

   initial begin
      idle_inputs(0);
      idle_inputs(1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Reset then idle.
      for (int c = 0; c < 10; c++) begin
         step(0, 1'b0, 4'b0, 0, 1'b0, 32'h0);
         step(1, 1'b0, 4'b0, 0, 1'b0, 32'h0);
      end

      // Sparse mask, registered output.
      step(0, 1'b1, 4'b1011, 0, 1'b0, 32'h100);
      check_eq("sparse_same_cycle_valid", deq_valid[0], 4'b0000);
      step(0, 1'b0, 4'b0, 0, 1'b0, 32'h0);
      check_eq("sparse_valid", deq_valid[0], 4'b0111);
      check_eq("sparse_pc0", deq_pc[0][31:0], 32'h100);
      check_eq("sparse_pc1", deq_pc[0][63:32], 32'h104);
      check_eq("sparse_pc2", deq_pc[0][95:64], 32'h10C);
      check_eq("sparse_count", count[0], 5'd3);
      step(0, 1'b0, 4'b0, 4, 1'b0, 32'h0);

      // Fill to full, dropped group while full, then one dequeue.
      for (int c = 0; c < 4; c++) step(0, 1'b1, 4'hF, 0, 1'b0, 32'h200 + 32'(c * 16));
      step(0, 1'b1, 4'hF, 4, 1'b0, 32'h900);
      check_eq("full_count", count[0], 5'd16);
      check_eq("full_ready", enq_ready[0], 1'b0);
      step(0, 1'b0, 4'b0, 0, 1'b0, 32'h0);
      check_eq("after_deq_count", count[0], 5'd12);
      check_eq("after_deq_ready", enq_ready[0], 1'b1);
      repeat (3) step(0, 1'b0, 4'b0, 4, 1'b0, 32'h0);

      // Steady enqueue 4 / dequeue 3 across pointer wrap.
      for (int c = 0; c < 40; c++) step(0, 1'b1, 4'hF, 3, 1'b0, 32'h1000 + 32'(c * 16));
      repeat (5) step(0, 1'b0, 4'b0, 4, 1'b0, 32'h0);
      check_eq("wrap_drained", count[0], 5'd0);

      // Bypass on empty queue with partial same-cycle consume.
      step(1, 1'b1, 4'hF, 2, 1'b0, 32'h2000);
      check_eq("byp_valid", deq_valid[1], 4'b1111);
      check_eq("byp_pc0", deq_pc[1][31:0], 32'h2000);
      check_eq("byp_pc1", deq_pc[1][63:32], 32'h2004);
      step(1, 1'b0, 4'b0, 0, 1'b0, 32'h0);
      check_eq("byp_rest_count", count[1], 5'd2);
      check_eq("byp_rest_valid", deq_valid[1], 4'b0011);
      check_eq("byp_rest_pc0", deq_pc[1][31:0], 32'h2008);
      check_eq("byp_rest_pc1", deq_pc[1][63:32], 32'h200C);
      step(1, 1'b0, 4'b0, 2, 1'b0, 32'h0);

      // Random masks, dequeue widths and occasional flushes on the bypass instance.
      for (int c = 0; c < 80; c++) begin
         step(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), int'($urandom_range(0, 4)),
              ($urandom_range(0, 15) == 0), 32'h4000 + 32'(c * 16));
      end
      repeat (5) step(1, 1'b0, 4'b0, 4, 1'b0, 32'h0);

      // Flush with a same-cycle enqueue at occupancy 9.
      step(0, 1'b1, 4'hF, 0, 1'b0, 32'h3000);
      step(0, 1'b1, 4'hF, 0, 1'b0, 32'h3010);
      step(0, 1'b1, 4'b0001, 0, 1'b0, 32'h3020);
      step(0, 1'b1, 4'hF, 0, 1'b1, 32'h3030);
      check_eq("flush_pre_count", count[0], 5'd9);
      step(0, 1'b0, 4'b0, 0, 1'b0, 32'h0);
      check_eq("flush_count", count[0], 5'd0);
      check_eq("flush_valid", deq_valid[0], 4'b0000);
      check_eq("flush_ready", enq_ready[0], 1'b1);

      // Reset mid-operation discards entries.
      step(1, 1'b1, 4'hF, 0, 1'b0, 32'h5000);
      step(1, 1'b1, 4'hF, 0, 1'b0, 32'h5010);
      do_reset();
      step(1, 1'b0, 4'b0, 0, 1'b0, 32'h0);
      check_eq("reset_count", count[1], 5'd0);
      check_eq("reset_valid", deq_valid[1], 4'b0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
